load_store_unit: RTL
====================

# load_store_unit

Initiator side of the CPU memory/IO request interface. Accepts one load or store at a time from the execute stage and decodes RV32I `funct3` into an access width and sign mode. It checks alignment, then issues a single-cycle request strobe to a memory or IO responder. It waits, with a timeout, for that responder's `operationOK` pulse, then returns extended load data or an exception code to the pipeline.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in WAIT before the access is failed; legal range is 2 or more.

Ports:
- `clk` input 1: clock; one clock domain.
- `rst` input 1: reset; synchronous, active-high.
- `req_In` input 1: request valid; sampled only while `ready_Out`=1.
- `isStore_In` input 1: 1 = store, 0 = load.
- `funct3_In` input 3: RV32I load/store `funct3`.
- `addr_In` input 32: byte address.
- `storeData_In` input 32: store data, right-justified.
- `ready_Out` output 1: unit is idle and can accept a request.
- `done_Out` output 1: one-cycle pulse; the result is valid in that cycle.
- `loadData_Out` output 32: extended load data; 0 for stores and for faults.
- `exception_Out` output `EXCEPTION_LEN`: result exception code.
- `mem_addr_Out` output 32: responder address.
- `mem_data_Out` output 32: responder write data, right-justified and masked to width.
- `mem_dataWidth_Out` output 2: `MEM_WIDTH_BYTE`/`HALF`/`WORD`.
- `mem_isRead_Out` output 1: responder read/write select.
- `mem_inputValid_Out` output 1: single-cycle request strobe.
- `mem_data_In` input 32: responder read data, right-justified.
- `mem_operationOK_In` input 1: responder completion pulse.
- `mem_exception_In` input `EXCEPTION_LEN`: responder exception; combinational from the request.

## Operation

States: IDLE, ISSUE, WAIT, DONE. `ready_Out` = (state == IDLE).

**IDLE**
- On `req_In`, latch the request and decode `funct3`:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Any other code: result `EXCEP_INVALID_MEM_READ` for a load, `EXCEP_INVALID_MEM_WRITE` for a store. Go to DONE without a bus request.
- Half access with `addr[0]`=1, or word access with `addr[1:0]`≠0: result `EXCEP_MISALIGNED_LOAD` or `EXCEP_MISALIGNED_STORE`. Go to DONE without a bus request.
- Otherwise go to ISSUE.

**ISSUE**
- Drive `mem_inputValid_Out`=1 for exactly this cycle.
- Sample `mem_exception_In` in this cycle:
  - If it is not `EXCEP_OK`, latch it as the result and go to DONE. A later `operationOK` from the responder is ignored.
  - Otherwise go to WAIT and clear the timeout counter.
- `mem_addr_Out`, `mem_dataWidth_Out`, `mem_isRead_Out` and `mem_data_Out` are held stable from ISSUE through WAIT. They are 0 in IDLE.

**WAIT**
- On `mem_operationOK_In`:
  - For a load, lane-extract the low byte or half of `mem_data_In`. Sign-extend for LB/LH; zero-extend for LBU/LHU/LW.
  - Result `EXCEP_OK`; go to DONE.
- Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1 without OK, set the result to `EXCEP_INVALID_MEM_READ` or `EXCEP_INVALID_MEM_WRITE` and go to DONE.

**DONE**
- `done_Out`=1 with `loadData_Out` and `exception_Out` valid.
- Next state is IDLE. Outputs return to 0 / `EXCEP_OK` in the following cycle.

Other rules:
- `mem_operationOK_In` is ignored in every state except WAIT.
- Store data sent on `mem_data_Out` is masked to width: SB sends `{24'b0, d[7:0]}`, SH sends `{16'b0, d[15:0]}`.

## Timing

- Reset: state IDLE; `done_Out`=0, `loadData_Out`=0, `exception_Out`=`EXCEP_OK`; all `mem_*_Out`=0. `ready_Out`=1 in the first cycle after `rst` falls.
- Successful access, with the request accepted at edge E0:
  - ISSUE (strobe high) occupies the cycle after E0.
  - The responder OK arrives the cycle after E1.
  - `done_Out` is high in the cycle after E2, i.e. 3 cycles after acceptance.
  - The next request is accepted at the edge after DONE.
- Decode fault: `done_Out` is high in the cycle after acceptance. The strobe never asserts.
- Responder exception: `done_Out` is high 2 cycles after acceptance.
- Timeout: `done_Out` is high `TIMEOUT_CYCLES`+2 cycles after acceptance.
- `req_In` asserted while not ready is dropped; there is no queueing.
- Reset in any state abandons the access, with no `done_Out` pulse. A stale responder OK arriving after reset is ignored, because the state is not WAIT.

## Structure

- `src/constants.v` gains:
  - `EXCEP_MISALIGNED_LOAD` and `EXCEP_MISALIGNED_STORE`.
  - `FUNCT3_LB`, `FUNCT3_LH`, `FUNCT3_LW`, `FUNCT3_LBU`, `FUNCT3_LHU`, `FUNCT3_SB`, `FUNCT3_SH`, `FUNCT3_SW`.
- Existing `MEM_WIDTH_*` and `EXCEP_*` macros are reused.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES)`.
- One sub-module: `load_extend`, a combinational unit mapping (width, unsigned flag, raw data) to extended data.

## Test plan

- **SW:** `addr`=0x0, `data`=0xDEADBEEF against the IO responder → one strobe cycle with addr 0x0, WORD, `isRead`=0, data 0xDEADBEEF. `done_Out` 3 cycles after acceptance with `EXCEP_OK` and `loadData_Out`=0.
- **LB then LBU:** `addr`=0x1, responder returns 0x00000080 → `loadData_Out` 0xFFFFFF80, then 0x00000080. `mem_dataWidth_Out`=BYTE.
- **LH misaligned:** `addr`=0x1 → `done_Out` the next cycle with `EXCEP_MISALIGNED_LOAD`. `mem_inputValid_Out` stays 0. `funct3`=011 on a store gives `EXCEP_INVALID_MEM_WRITE`.
- **LW out of range:** `addr`=0x4 to the IO responder → `EXCEP_INVALID_MEM_READ`, `done_Out` 2 cycles after acceptance, `loadData_Out`=0. The following OK pulse is ignored.
- **Timeout:** `TIMEOUT_CYCLES`=4, stub responder never asserts OK → `EXCEP_INVALID_MEM_READ` 6 cycles after acceptance. An OK injected one cycle later has no effect, and the next request completes normally.
- **Reset in WAIT:** next cycle shows all outputs at reset values with no `done_Out`. `ready_Out`=1 after `rst` falls. A stale OK is ignored. A back-to-back SB with `data`=0x12345678 sends 0x00000078.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: exception codes,
// RV32I load/store funct3 encodings, access widths and a store-masking helper.
package load_store_unit_pkg;

  localparam int EXCEPTION_LEN = 4;

  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd1;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd2;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED_LOAD   = 4'd3;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED_STORE  = 4'd4;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MEM_WIDTH_BYTE = 2'd0,
    MEM_WIDTH_HALF = 2'd1,
    MEM_WIDTH_WORD = 2'd2
  } mem_width_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  function automatic logic [31:0] mask_store(mem_width_e w, logic [31:0] d);
    case (w)
      MEM_WIDTH_BYTE: return {24'b0, d[7:0]};
      MEM_WIDTH_HALF: return {16'b0, d[15:0]};
      default:        return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus between the load/store unit (master) and a memory or
// IO responder (slave).
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic [31:0]              mem_addr_Out;
  logic [31:0]              mem_data_Out;
  logic [1:0]               mem_dataWidth_Out;
  logic                     mem_isRead_Out;
  logic                     mem_inputValid_Out;
  logic [31:0]              mem_data_In;
  logic                     mem_operationOK_In;
  logic [EXCEPTION_LEN-1:0] mem_exception_In;

  modport master (
    output mem_addr_Out, mem_data_Out, mem_dataWidth_Out, mem_isRead_Out, mem_inputValid_Out,
    input  mem_data_In, mem_operationOK_In, mem_exception_In
  );

  modport slave (
    input  mem_addr_Out, mem_data_Out, mem_dataWidth_Out, mem_isRead_Out, mem_inputValid_Out,
    output mem_data_In, mem_operationOK_In, mem_exception_In
  );
endinterface

// File: rtl/load_store_unit_extend.sv
// Combinational lane extraction and sign/zero extension of right-justified
// load data for byte, half and word accesses.
module load_extend
  import load_store_unit_pkg::*;
(
  input  mem_width_e  width_i,
  input  logic        unsigned_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic sign_bit;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    sign_bit = 1'b0;
    data_o   = data_i;
    case (width_i)
      MEM_WIDTH_BYTE: begin
        sign_bit = ~unsigned_i & data_i[7];
        data_o   = {{24{sign_bit}}, data_i[7:0]};
      end
      MEM_WIDTH_HALF: begin
        sign_bit = ~unsigned_i & data_i[15];
        data_o   = {{16{sign_bit}}, data_i[15:0]};
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: decodes funct3, checks alignment, issues one request
// strobe, waits (with timeout) for the responder and returns the result.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_In,
  input  logic                     isStore_In,
  input  logic [2:0]               funct3_In,
  input  logic [31:0]              addr_In,
  input  logic [31:0]              storeData_In,
  output logic                     ready_Out,
  output logic                     done_Out,
  output logic [31:0]              loadData_Out,
  output logic [EXCEPTION_LEN-1:0] exception_Out,
  load_store_unit_if.master        mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e               state_q, state_d;
  logic                     is_store_q, is_store_d;
  mem_width_e               width_q, width_d;
  logic                     uns_q, uns_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [EXCEPTION_LEN-1:0] exc_q, exc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic       dec_valid, dec_uns, dec_misaligned;
  mem_width_e dec_width;
  logic [31:0] ext_data;
  logic        busy;

  // Store and load encodings share 000/001/010; only loads have the unsigned forms.
  always_comb begin
    dec_valid = 1'b1;
    dec_uns   = 1'b0;
    dec_width = MEM_WIDTH_WORD;
    case (funct3_In)
      FUNCT3_LB:  dec_width = MEM_WIDTH_BYTE;
      FUNCT3_LH:  dec_width = MEM_WIDTH_HALF;
      FUNCT3_LW:  dec_width = MEM_WIDTH_WORD;
      FUNCT3_LBU: begin dec_width = MEM_WIDTH_BYTE; dec_uns = 1'b1; dec_valid = ~isStore_In; end
      FUNCT3_LHU: begin dec_width = MEM_WIDTH_HALF; dec_uns = 1'b1; dec_valid = ~isStore_In; end
      default:    dec_valid = 1'b0;
    endcase
    dec_misaligned = ((dec_width == MEM_WIDTH_HALF) && addr_In[0]) ||
                     ((dec_width == MEM_WIDTH_WORD) && (addr_In[1:0] != 2'b00));
  end

  load_extend u_load_extend (
    .width_i    (width_q),
    .unsigned_i (uns_q),
    .data_i     (mem.mem_data_In),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    width_d    = width_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    exc_d      = exc_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: if (req_In) begin
        is_store_d = isStore_In;
        width_d    = dec_width;
        uns_d      = dec_uns;
        addr_d     = addr_In;
        wdata_d    = isStore_In ? mask_store(dec_width, storeData_In) : 32'd0;
        rdata_d    = 32'd0;
        exc_d      = EXCEP_OK;
        if (!dec_valid) begin
          exc_d   = isStore_In ? EXCEP_INVALID_MEM_WRITE : EXCEP_INVALID_MEM_READ;
          state_d = ST_DONE;
        end else if (dec_misaligned) begin
          exc_d   = isStore_In ? EXCEP_MISALIGNED_STORE : EXCEP_MISALIGNED_LOAD;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem.mem_exception_In != EXCEP_OK) begin
          exc_d   = mem.mem_exception_In;
          state_d = ST_DONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_operationOK_In) begin
          rdata_d = is_store_q ? 32'd0 : ext_data;
          exc_d   = EXCEP_OK;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          exc_d   = is_store_q ? EXCEP_INVALID_MEM_WRITE : EXCEP_INVALID_MEM_READ;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the request/result registers are left without reset; they are only
  // visible through outputs gated by state, and state itself is reset.
  always_ff @(posedge clk) begin
    is_store_q <= is_store_d;
    width_q    <= width_d;
    uns_q      <= uns_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    rdata_q    <= rdata_d;
    exc_q      <= exc_d;
  end

  assign busy          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign ready_Out     = (state_q == ST_IDLE);
  assign done_Out      = (state_q == ST_DONE);
  assign loadData_Out  = done_Out ? rdata_q : 32'd0;
  assign exception_Out = done_Out ? exc_q : EXCEP_OK;

  assign mem.mem_addr_Out       = busy ? addr_q : 32'd0;
  assign mem.mem_data_Out       = busy ? wdata_q : 32'd0;
  assign mem.mem_dataWidth_Out  = busy ? width_q : MEM_WIDTH_BYTE;
  assign mem.mem_isRead_Out     = busy & ~is_store_q;
  assign mem.mem_inputValid_Out = (state_q == ST_ISSUE);

endmodule
